div_ctrl: RTL

- Multi-cycle 32-bit divide sequencer that sits beside the EX stage and produces the HI/LO result for DIV/DIVU.
- Radix-2 restoring algorithm: one quotient bit per clock.
- Requests a pipeline stall while a divide is in flight and returns {remainder, quotient} for the HI/LO write path.
- Accepts an annul so a squashed instruction can abandon the operation.

---
 rtl/div_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle radix-2 restoring divider for DIV/DIVU beside EX.
// Produces {remainder, quotient} for the HI/LO write path and stalls the
// pipeline while a divide is in flight.
// Optional feature macro: DIV_EARLY_OUT_EN (skip iterations when |dividend| < |divisor|).
module div_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  annul_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  stallreq_o
);

  typedef enum logic [1:0] {StIdle, StByZero, StOn, StEnd} state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DATA_W - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]     rem_q, rem_d;        // partial remainder
  logic [DATA_W-1:0]     dvd_q, dvd_d;        // dividend shifting out, quotient shifting in
  logic [DATA_W-1:0]     dvs_q, dvs_d;        // divisor magnitude
  logic                  neg_quot_q, neg_quot_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0]   result_q, result_d;
  logic                  ready_q, ready_d;

  // Operand magnitudes and signs as seen at acceptance.
  logic              op1_neg, op2_neg;
  logic [DATA_W-1:0] op1_mag, op2_mag;
  always_comb begin
    op1_neg = signed_div_i & opdata1_i[DATA_W-1];
    op2_neg = signed_div_i & opdata2_i[DATA_W-1];
    op1_mag = op1_neg ? -opdata1_i : opdata1_i;
    op2_mag = op2_neg ? -opdata2_i : opdata2_i;
  end

  logic early_out;
`ifdef DIV_EARLY_OUT_EN
  assign early_out = (op1_mag < op2_mag);
`else
  assign early_out = 1'b0;
`endif

  // One restoring iteration plus the signed fix-up used on the final edge.
  logic [DATA_W:0]   part;
  logic              quot_bit;
  logic [DATA_W-1:0] rem_nxt, quot_nxt, rem_fix, quot_fix;
  always_comb begin
    part     = {rem_q, dvd_q[DATA_W-1]};
    quot_bit = (part >= {1'b0, dvs_q});
    rem_nxt  = quot_bit ? DATA_W'(part - {1'b0, dvs_q}) : part[DATA_W-1:0];
    quot_nxt = {dvd_q[DATA_W-2:0], quot_bit};
    quot_fix = neg_quot_q ? -quot_nxt : quot_nxt;
    rem_fix  = neg_rem_q ? -rem_nxt : rem_nxt;
  end

  // Next-state logic for the sequencer and its datapath registers.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && !annul_i) begin
          cnt_d      = '0;
          rem_d      = '0;
          dvd_d      = op1_mag;
          dvs_d      = op2_mag;
          neg_quot_d = op1_neg ^ op2_neg;
          neg_rem_d  = op1_neg;
          if (opdata2_i == '0) begin
            state_d = StByZero;
          end else if (early_out) begin
            state_d  = StEnd;
            result_d = {opdata1_i, {DATA_W{1'b0}}};
          end else begin
            state_d = StOn;
          end
        end
      end
      StByZero: begin
        if (annul_i) begin
          state_d = StIdle;
        end else begin
          state_d  = StEnd;
          result_d = '0;
        end
      end
      StOn: begin
        if (annul_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          rem_d = rem_nxt;
          dvd_d = quot_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d  = StEnd;
            result_d = {rem_fix, quot_fix};
          end
        end
      end
      StEnd: begin
        // Annul behaves like start dropping; result cleared on the way out.
        if (!start_i || annul_i) begin
          state_d  = StIdle;
          ready_d  = 1'b0;
          result_d = '0;
        end else begin
          ready_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  // Stall drops in the cycle ready is seen so EX advances exactly once.
  always_comb begin
    result_o   = result_q;
    ready_o    = ready_q;
    stallreq_o = start_i & ~annul_i & ~ready_q;
  end

endmodule
